ff_excitation_gen: RTL and testbench

Excitation generator and cross-checker for the flip-flop conversion family. It takes a target D-bit stream and derives the S/R, J/K and T excitation each flip-flop type needs to follow that stream. It drives three internal model flip-flops (SR, JK, T) with those excitations and compares their outputs against a D-reference register. It is the inverse of the D-from-SR/JK/T converters: it produces the excitation instead of consuming it, and serves as a self-checking source for those benches.

---
 rtl/ff_exc_pkg.sv | 23 ++
 rtl/ff_excitation_gen_if.sv | 39 +++
 rtl/ff_exc_encode.sv | 35 +++
 rtl/ff_excitation_gen.sv | 155 +++++++++++++++
 tb/tb_ff_excitation_gen.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/ff_exc_pkg.sv
// ff_exc_pkg
// Shared types for the flip-flop excitation generator:
//   state_t : FSM state encoding (IDLE=0, RUN=1, HALT=2), STATE_W bits wide
//   exc_t   : bundle of the five excitation bits {s, r, j, k, t}
package ff_exc_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  typedef struct packed {
    logic s;
    logic r;
    logic j;
    logic k;
    logic t;
  } exc_t;

endpackage

// File: rtl/ff_excitation_gen_if.sv
// ff_excitation_gen_if
// Stream and status bundle of the excitation generator.
//   Stimulus (master -> slave): d_in, d_valid, inj
//   Status   (slave -> master): s_out, r_out, j_out, k_out, t_out,
//                               q_ref, q_sr, q_jk, q_t, mismatch,
//                               err_cnt[CNT_W-1:0], state[1:0]
// The generator core connects through the slave modport; the stimulus
// source connects through the master modport.
interface ff_excitation_gen_if #(
  parameter int CNT_W = 8
);
  logic             d_in;
  logic             d_valid;
  logic             inj;
  logic             s_out;
  logic             r_out;
  logic             j_out;
  logic             k_out;
  logic             t_out;
  logic             q_ref;
  logic             q_sr;
  logic             q_jk;
  logic             q_t;
  logic             mismatch;
  logic [CNT_W-1:0] err_cnt;
  logic [1:0]       state;

  modport master (
    output d_in, d_valid, inj,
    input  s_out, r_out, j_out, k_out, t_out,
    input  q_ref, q_sr, q_jk, q_t, mismatch, err_cnt, state
  );

  modport slave (
    input  d_in, d_valid, inj,
    output s_out, r_out, j_out, k_out, t_out,
    output q_ref, q_sr, q_jk, q_t, mismatch, err_cnt, state
  );
endinterface

// File: rtl/ff_exc_encode.sv
// ff_exc_encode
// Purely combinational excitation encoder.
//   d   in  : target next state
//   q   in  : present (reference) state
//   exc out : {s, r, j, k, t} excitation that moves q to d
// Build option FF_EXC_DONTCARE_EN selects the minimal don't-care encoding
// (S=J=d, R=K=~d); otherwise the strict encoding drives S/R/J/K only when
// the state actually changes. T is d^q in both builds.
module ff_exc_encode
  import ff_exc_pkg::*;
(
  input  logic d,
  input  logic q,
  output exc_t exc
);

  always_comb begin
    exc = '0;
`ifdef FF_EXC_DONTCARE_EN
    // Redundant set/clear drive lands in the don't-care columns of the
    // excitation tables, so the present state is not needed here.
    exc.s = d;
    exc.r = ~d;
    exc.j = d;
    exc.k = ~d;
`else
    exc.s = d & ~q;
    exc.r = ~d & q;
    exc.j = d & ~q;
    exc.k = ~d & q;
`endif
    exc.t = d ^ q;
  end

endmodule

// File: rtl/ff_excitation_gen.sv
// ff_excitation_gen
// Derives SR/JK/T excitations from a target D stream, drives three model
// flip-flops with them and cross-checks the models against a D reference.
//   clk, rst : clock and synchronous active-high reset
//   bus      : ff_excitation_gen_if.slave (stimulus in, excitations, model
//              states, mismatch, saturating err_cnt and FSM state out)
// Parameters: CNT_W (err_cnt width), STOP_ON_ERR (1: first mismatch halts).
// Build option FF_EXC_DONTCARE_EN (inside ff_exc_encode) selects the
// don't-care excitation encoding; model behaviour is identical either way.
module ff_excitation_gen
  import ff_exc_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int STOP_ON_ERR = 1
) (
  input  logic                clk,
  input  logic                rst,
  ff_excitation_gen_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic             q_ref_q, q_ref_d;
  logic             q_sr_q, q_sr_d;
  logic             q_jk_q, q_jk_d;
  logic             q_t_q, q_t_d;
  logic             s_out_q, s_out_d;
  logic             r_out_q, r_out_d;
  logic             j_out_q, j_out_d;
  logic             k_out_q, k_out_d;
  logic             t_out_q, t_out_d;
  logic             mismatch_q, mismatch_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  exc_t exc;
  logic accept;
  logic t_apply;

  // Excitation is always derived from the reference state, so a diverged
  // model keeps being driven as if it were aligned.
  ff_exc_encode u_encode (
    .d   (bus.d_in),
    .q   (q_ref_q),
    .exc (exc)
  );

  always_comb begin
    state_d    = state_q;
    q_ref_d    = q_ref_q;
    q_sr_d     = q_sr_q;
    q_jk_d     = q_jk_q;
    q_t_d      = q_t_q;
    s_out_d    = 1'b0;
    r_out_d    = 1'b0;
    j_out_d    = 1'b0;
    k_out_d    = 1'b0;
    t_out_d    = 1'b0;
    mismatch_d = 1'b0;
    err_cnt_d  = err_cnt_q;

    accept  = bus.d_valid && (state_q != ST_HALT);
    t_apply = exc.t ^ bus.inj;

    if (accept) begin
      q_ref_d = bus.d_in;

      if (exc.s)      q_sr_d = 1'b1;
      else if (exc.r) q_sr_d = 1'b0;

      case ({exc.j, exc.k})
        2'b10:   q_jk_d = 1'b1;
        2'b01:   q_jk_d = 1'b0;
        2'b11:   q_jk_d = ~q_jk_q;
        default: q_jk_d = q_jk_q;
      endcase

      q_t_d   = q_t_q ^ t_apply;

      s_out_d = exc.s;
      r_out_d = exc.r;
      j_out_d = exc.j;
      k_out_d = exc.k;
      t_out_d = t_apply;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.d_valid) state_d = ST_RUN;
      end
      ST_RUN: begin
        // Registered model states already reflect the previous sample,
        // giving the two-cycle compare latency.
        mismatch_d = (q_sr_q != q_ref_q) | (q_jk_q != q_ref_q) | (q_t_q != q_ref_q);
        if (mismatch_q && (err_cnt_q != CNT_MAX)) err_cnt_d = err_cnt_q + 1'b1;
        if (mismatch_q && (STOP_ON_ERR != 0))     state_d   = ST_HALT;
      end
      ST_HALT: begin
        mismatch_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      q_ref_q    <= 1'b0;
      q_sr_q     <= 1'b0;
      q_jk_q     <= 1'b0;
      q_t_q      <= 1'b0;
      s_out_q    <= 1'b0;
      r_out_q    <= 1'b0;
      j_out_q    <= 1'b0;
      k_out_q    <= 1'b0;
      t_out_q    <= 1'b0;
      mismatch_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      q_ref_q    <= q_ref_d;
      q_sr_q     <= q_sr_d;
      q_jk_q     <= q_jk_d;
      q_t_q      <= q_t_d;
      s_out_q    <= s_out_d;
      r_out_q    <= r_out_d;
      j_out_q    <= j_out_d;
      k_out_q    <= k_out_d;
      t_out_q    <= t_out_d;
      mismatch_q <= mismatch_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // Set and clear must never be requested together in either encoding.
  a_no_sr_jk_conflict : assert property (
    @(posedge clk) disable iff (rst) !(exc.s && exc.r) && !(exc.j && exc.k)
  );

  assign bus.s_out    = s_out_q;
  assign bus.r_out    = r_out_q;
  assign bus.j_out    = j_out_q;
  assign bus.k_out    = k_out_q;
  assign bus.t_out    = t_out_q;
  assign bus.q_ref    = q_ref_q;
  assign bus.q_sr     = q_sr_q;
  assign bus.q_jk     = q_jk_q;
  assign bus.q_t      = q_t_q;
  assign bus.mismatch = mismatch_q;
  assign bus.err_cnt  = err_cnt_q;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_ff_excitation_gen.sv
// tb_ff_excitation_gen
// Two instances: dut_a halts on the first mismatch, dut_b keeps running.
// Stimulus steps push the hand-derived expected output snapshot for the
// upcoming edge into a per-instance queue; a negedge monitor pops and
// compares. Snapshot = {s,r,j,k,t, q_ref,q_sr,q_jk,q_t, mismatch, state, err_cnt}.
module tb_ff_excitation_gen;

`ifdef FF_EXC_DONTCARE_EN
  localparam bit DC = 1'b1;
`else
  localparam bit DC = 1'b0;
`endif

  typedef struct {
    string       name;
    int          cyc;
    logic [19:0] exp;
  } rec_t;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  rec_t qa[$];
  rec_t qb[$];
  rec_t rec;

  ff_excitation_gen_if #(.CNT_W(8)) ifa ();
  ff_excitation_gen_if #(.CNT_W(8)) ifb ();

  ff_excitation_gen #(.CNT_W(8), .STOP_ON_ERR(1)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (ifa)
  );

  ff_excitation_gen #(.CNT_W(8), .STOP_ON_ERR(0)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (ifb)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [19:0] snap_a();
    return {ifa.s_out, ifa.r_out, ifa.j_out, ifa.k_out, ifa.t_out,
            ifa.q_ref, ifa.q_sr, ifa.q_jk, ifa.q_t, ifa.mismatch,
            ifa.state, ifa.err_cnt};
  endfunction

  function automatic logic [19:0] snap_b();
    return {ifb.s_out, ifb.r_out, ifb.j_out, ifb.k_out, ifb.t_out,
            ifb.q_ref, ifb.q_sr, ifb.q_jk, ifb.q_t, ifb.mismatch,
            ifb.state, ifb.err_cnt};
  endfunction

  // exc is the strict-encoding {s,r,j,k,t}; in the don't-care build the
  // s/r/j/k fields of an accepted edge become {d,~d,d,~d}.
  task automatic step(input int which, input string name, input bit rs,
                      input bit v, input bit d, input bit i, input bit acc,
                      input logic [4:0] exc, input logic [3:0] qv,
                      input logic mm, input logic [1:0] st,
                      input logic [7:0] err);
    logic [4:0] e;
    rec_t r;
    @(posedge clk);
    #1;
    e = exc;
    if (DC) e[4:1] = acc ? {d, ~d, d, ~d} : 4'b0000;
    r.name = name;
    r.cyc  = cyc + 1;
    r.exp  = {e, qv, mm, st, err};
    if (which == 0) begin
      rst_a = rs; ifa.d_valid = v; ifa.d_in = d; ifa.inj = i;
      qa.push_back(r);
    end else begin
      rst_b = rs; ifb.d_valid = v; ifb.d_in = d; ifb.inj = i;
      qb.push_back(r);
    end
  endtask

  always @(negedge clk) begin
    while (qa.size() > 0 && qa[0].cyc == cyc) begin
      rec = qa.pop_front();
      vectors++;
      if (snap_a() !== rec.exp) begin
        miscompares++;
        $display("FAIL a:%s cyc=%0d got=%h exp=%h", rec.name, cyc, snap_a(), rec.exp);
      end else
        $display("ok   a:%s cyc=%0d val=%h", rec.name, cyc, rec.exp);
    end
    while (qb.size() > 0 && qb[0].cyc == cyc) begin
      rec = qb.pop_front();
      vectors++;
      if (snap_b() !== rec.exp) begin
        miscompares++;
        $display("FAIL b:%s cyc=%0d got=%h exp=%h", rec.name, cyc, snap_b(), rec.exp);
      end else
        $display("ok   b:%s cyc=%0d val=%h", rec.name, cyc, rec.exp);
    end
  end

  initial begin
    ifa.d_in = 1'b0; ifa.d_valid = 1'b0; ifa.inj = 1'b0;
    ifb.d_in = 1'b0; ifb.d_valid = 1'b0; ifb.inj = 1'b0;

    //        which name        rs v d i acc exc       q        mm st err
    step(0, "rst0",      1, 0, 0, 0, 0, 5'b00000, 4'b0000, 0, 2'd0, 8'd0);
    step(0, "rst1",      1, 1, 1, 0, 0, 5'b00000, 4'b0000, 0, 2'd0, 8'd0);
    step(0, "idle0",     0, 0, 0, 0, 0, 5'b00000, 4'b0000, 0, 2'd0, 8'd0);
    step(0, "idle1",     0, 0, 1, 0, 0, 5'b00000, 4'b0000, 0, 2'd0, 8'd0);
    step(0, "alt0",      0, 1, 0, 0, 1, 5'b00000, 4'b0000, 0, 2'd1, 8'd0);
    step(0, "alt1",      0, 1, 1, 0, 1, 5'b10101, 4'b1111, 0, 2'd1, 8'd0);
    step(0, "alt2",      0, 1, 0, 0, 1, 5'b01011, 4'b0000, 0, 2'd1, 8'd0);
    step(0, "alt3",      0, 1, 1, 0, 1, 5'b10101, 4'b1111, 0, 2'd1, 8'd0);
    step(0, "rep0",      0, 1, 1, 0, 1, 5'b00000, 4'b1111, 0, 2'd1, 8'd0);
    step(0, "rep1",      0, 1, 1, 0, 1, 5'b00000, 4'b1111, 0, 2'd1, 8'd0);
    step(0, "rep2",      0, 1, 1, 0, 1, 5'b00000, 4'b1111, 0, 2'd1, 8'd0);
    step(0, "clr",       0, 1, 0, 0, 1, 5'b01011, 4'b0000, 0, 2'd1, 8'd0);
    step(0, "gap0",      0, 0, 1, 0, 0, 5'b00000, 4'b0000, 0, 2'd1, 8'd0);
    step(0, "gap1",      0, 0, 1, 0, 0, 5'b00000, 4'b0000, 0, 2'd1, 8'd0);
    step(0, "inj",       0, 1, 1, 1, 1, 5'b10100, 4'b1110, 0, 2'd1, 8'd0);
    step(0, "inj_n1",    0, 0, 0, 0, 0, 5'b00000, 4'b1110, 1, 2'd1, 8'd0);
    step(0, "inj_n2",    0, 0, 0, 0, 0, 5'b00000, 4'b1110, 1, 2'd2, 8'd1);
    step(0, "halt0",     0, 1, 0, 1, 0, 5'b00000, 4'b1110, 1, 2'd2, 8'd1);
    step(0, "halt1",     0, 1, 1, 0, 0, 5'b00000, 4'b1110, 1, 2'd2, 8'd1);
    step(0, "rst_mid",   1, 1, 1, 0, 0, 5'b00000, 4'b0000, 0, 2'd0, 8'd0);
    step(0, "post_rst",  0, 1, 1, 0, 1, 5'b10101, 4'b1111, 0, 2'd1, 8'd0);
    step(0, "quiet",     0, 0, 0, 0, 0, 5'b00000, 4'b1111, 0, 2'd1, 8'd0);

    step(1, "b_rst",     1, 0, 0, 0, 0, 5'b00000, 4'b0000, 0, 2'd0, 8'd0);
    step(1, "b_inj",     0, 1, 1, 1, 1, 5'b10100, 4'b1110, 0, 2'd1, 8'd0);
    for (int k = 1; k < 300; k++) begin
      step(1, "b_run", 0, 1, 1, 0, 1, 5'b00000, 4'b1110, 1, 2'd1,
           (k < 2) ? 8'd0 : ((k - 1 > 255) ? 8'd255 : 8'(k - 1)));
    end
    step(1, "b_end",     0, 0, 0, 0, 0, 5'b00000, 4'b1110, 1, 2'd1, 8'd255);

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    vectors++;
    if (qa.size() != 0 || qb.size() != 0) begin
      miscompares++;
      $display("FAIL drain got=%0d/%0d pending exp=0/0", qa.size(), qb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
